// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   PS/2 keyboard receiver and key-state tracker. Raw ps2_clk/ps2_data are
//   synchronised. Each 11-bit frame is deserialised and checked for start,
//   parity and stop errors. Good bytes go to a make/break/E0 decoder, which
//   keeps the held key and counts new presses.
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   ps2_clk, ps2_data raw keyboard lines (asynchronous)
//   key_code, key_ext held (or last held) key and its E0 flag
//   pressed           a key is currently held
//   press_cnt         count of new presses, wraps at 255
//   byte_valid        one-cycle pulse per good frame
//   rx_byte           data byte of the last good frame
//   frame_err         last frame was bad or timed out
module ps2_key_tracker #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       pressed,
  output logic [7:0] press_cnt,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Frame is good when start=0, stop=1 and data+parity has an odd count of ones.
  // sh holds bits 0..9 with bit0 in sh[0].
  function automatic logic frame_ok(input logic [9:0] sh, input logic stop);
    frame_ok = ~sh[0] & stop & (^sh[9:1]);
  endfunction

  logic [2:0]    sync_clk, sync_data;
  logic          fall, din;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  state_t     state, state_n;
  logic [7:0] key_code_n, press_cnt_n;
  logic       key_ext_n, pressed_n;

  // ---- synchroniser stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_clk  <= 3'b111;
      sync_data <= 3'b111;
    end else begin
      sync_clk  <= {sync_clk[1:0], ps2_clk};
      sync_data <= {sync_data[1:0], ps2_data};
    end
  end

  assign fall    = (sync_clk[2:1] == 2'b10);
  assign din     = sync_data[1];
  assign tmo_hit = (bit_cnt != 4'd0) && (tmo_cnt == TW'(TIMEOUT));

  // ---- frame receive stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shreg      <= 10'd0;
      tmo_cnt    <= '0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;

      if (fall || bit_cnt == 4'd0 || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        // Partial frame is dropped; a coincident edge starts a fresh frame.
        frame_err <= 1'b1;
        bit_cnt   <= fall ? 4'd1 : 4'd0;
        if (fall)
          shreg <= {din, shreg[9:1]};
      end else if (fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok(shreg, din)) begin
            rx_byte    <= shreg[8:1];
            byte_valid <= 1'b1;
            frame_err  <= 1'b0;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {din, shreg[9:1]};
        end
      end
    end
  end

  // ---- decoder stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= 8'd0;
      key_ext   <= 1'b0;
      pressed   <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      key_code  <= key_code_n;
      key_ext   <= key_ext_n;
      pressed   <= pressed_n;
      press_cnt <= press_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    key_code_n  = key_code;
    key_ext_n   = key_ext;
    pressed_n   = pressed;
    press_cnt_n = press_cnt;
    if (byte_valid) begin
      unique case (state)
        IDLE, EXT: begin
          if (state == IDLE && rx_byte == 8'hE0) begin
            state_n = EXT;
          end else if (rx_byte == 8'hF0) begin
            state_n = (state == IDLE) ? BRK : EXT_BRK;
          end else begin
            // Make code; typematic repeats of the held key do not count.
            if (!pressed || {state == EXT, rx_byte} != {key_ext, key_code})
              press_cnt_n = press_cnt + 8'd1;
            key_code_n = rx_byte;
            key_ext_n  = (state == EXT);
            pressed_n  = 1'b1;
            state_n    = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          if ({state == EXT_BRK, rx_byte} == {key_ext, key_code})
            pressed_n = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code, press_cnt, rx_byte;
  logic       key_ext, pressed, byte_valid, frame_err;

  ps2_key_tracker #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_ext(key_ext), .pressed(pressed),
    .press_cnt(press_cnt), .byte_valid(byte_valid), .rx_byte(rx_byte),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int bv_cnt = 0;
  always @(posedge clk) if (byte_valid) bv_cnt <= bv_cnt + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(4);
    ps2_clk = 1'b0;
    wait_clk(6);
    ps2_clk = 1'b1;
    wait_clk(4);
  endtask

  // Sends bits 0..nbits-1 of a frame for byte d; flip inverts the parity bit.
  task automatic send_bits(input logic [7:0] d, input logic flip, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    send_bits(d, flip, 11);
    wait_clk(10);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       bad;
    int         bv;
    logic [7:0] rx;
    logic [7:0] kc;
    logic       ext;
    logic       pr;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  vec_t vec[17];

  initial begin
    int bv0;
    logic [7:0] c0;

    //           data   bad  bv  rx     kc     ext   pr    cnt    err
    vec[0]  = '{8'h1C, 1'b0, 1, 8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[1]  = '{8'h1C, 1'b0, 1, 8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[2]  = '{8'h1C, 1'b0, 1, 8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[3]  = '{8'h1C, 1'b0, 1, 8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[4]  = '{8'hF0, 1'b0, 1, 8'hF0, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[5]  = '{8'h1C, 1'b0, 1, 8'h1C, 8'h1C, 1'b0, 1'b0, 8'd1, 1'b0};
    vec[6]  = '{8'hE0, 1'b0, 1, 8'hE0, 8'h1C, 1'b0, 1'b0, 8'd1, 1'b0};
    vec[7]  = '{8'h75, 1'b0, 1, 8'h75, 8'h75, 1'b1, 1'b1, 8'd2, 1'b0};
    vec[8]  = '{8'hE0, 1'b0, 1, 8'hE0, 8'h75, 1'b1, 1'b1, 8'd2, 1'b0};
    vec[9]  = '{8'hF0, 1'b0, 1, 8'hF0, 8'h75, 1'b1, 1'b1, 8'd2, 1'b0};
    vec[10] = '{8'h75, 1'b0, 1, 8'h75, 8'h75, 1'b1, 1'b0, 8'd2, 1'b0};
    vec[11] = '{8'hE0, 1'b0, 1, 8'hE0, 8'h75, 1'b1, 1'b0, 8'd2, 1'b0};
    vec[12] = '{8'h75, 1'b0, 1, 8'h75, 8'h75, 1'b1, 1'b1, 8'd3, 1'b0};
    vec[13] = '{8'hF0, 1'b0, 1, 8'hF0, 8'h75, 1'b1, 1'b1, 8'd3, 1'b0};
    vec[14] = '{8'h75, 1'b0, 1, 8'h75, 8'h75, 1'b1, 1'b1, 8'd3, 1'b0};
    vec[15] = '{8'h1C, 1'b1, 0, 8'h75, 8'h75, 1'b1, 1'b1, 8'd3, 1'b1};
    vec[16] = '{8'h1B, 1'b0, 1, 8'h1B, 8'h1B, 1'b0, 1'b1, 8'd4, 1'b0};

    // Reset, then a mid-frame reset after 5 bits.
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    send_bits(8'h1C, 1'b0, 5);
    rst = 1'b1;
    #1;
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_ext", 32'(key_ext), 32'h0);
    check("rst_pressed", 32'(pressed), 32'h0);
    check("rst_press_cnt", 32'(press_cnt), 32'h0);
    check("rst_byte_valid", 32'(byte_valid), 32'h0);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_bit_cnt", 32'(dut.bit_cnt), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);

    // Table-driven: typematic, extended, break mismatch, parity error.
    for (int i = 0; i < 17; i++) begin
      bv0 = bv_cnt;
      send_frame(vec[i].data, vec[i].bad);
      check($sformatf("v%0d_byte_valid_cnt", i), 32'(bv_cnt - bv0), 32'(vec[i].bv));
      check($sformatf("v%0d_rx_byte", i), 32'(rx_byte), 32'(vec[i].rx));
      check($sformatf("v%0d_key_code", i), 32'(key_code), 32'(vec[i].kc));
      check($sformatf("v%0d_key_ext", i), 32'(key_ext), 32'(vec[i].ext));
      check($sformatf("v%0d_pressed", i), 32'(pressed), 32'(vec[i].pr));
      check($sformatf("v%0d_press_cnt", i), 32'(press_cnt), 32'(vec[i].cnt));
      check($sformatf("v%0d_frame_err", i), 32'(frame_err), 32'(vec[i].err));
    end

    // Timeout: 6 bits then idle.
    send_bits(8'h1C, 1'b0, 6);
    check("tmo_bit_cnt_mid", 32'(dut.bit_cnt), 32'd6);
    wait_clk(60);
    check("tmo_not_yet", 32'(frame_err), 32'h0);
    wait_clk(60);
    check("tmo_frame_err", 32'(frame_err), 32'h1);
    check("tmo_bit_cnt", 32'(dut.bit_cnt), 32'h0);
    bv0 = bv_cnt;
    send_frame(8'h1C, 1'b0);
    check("tmo_after_bv", 32'(bv_cnt - bv0), 32'd1);
    check("tmo_after_rx", 32'(rx_byte), 32'h1C);
    check("tmo_after_err", 32'(frame_err), 32'h0);
    check("tmo_after_kc", 32'(key_code), 32'h1C);
    check("tmo_after_cnt", 32'(press_cnt), 32'd5);

    // Wrap: 256 distinct alternating makes, starting with 0x1B while 0x1C held.
    c0 = press_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame((i % 2 == 0) ? 8'h1B : 8'h1C, 1'b0);
      if (8'(c0 + 8'(i + 1)) == 8'd0)
        check("wrap_zero", 32'(press_cnt), 32'h0);
    end
    check("wrap_final", 32'(press_cnt), 32'(c0));
    check("wrap_kc", 32'(key_code), 32'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
